// File: rtl/datapath_ctrl_fsm_pkg.sv
// Shared definitions for the writeback-mux control sequencer: opcodes,
// mux select codes (also used where the 6-input writeback mux is instantiated),
// ALU op codes, FSM state encoding and small opcode decode helpers.
package datapath_ctrl_fsm_pkg;

  // Instruction opcodes, instr[15:12]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JAL  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_CLR  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Writeback mux select codes
  localparam logic [2:0] SEL_ALU  = 3'd0;
  localparam logic [2:0] SEL_MEM  = 3'd1;
  localparam logic [2:0] SEL_IMM  = 3'd2;
  localparam logic [2:0] SEL_PC1  = 3'd3;
  localparam logic [2:0] SEL_REGB = 3'd4;
  localparam logic [2:0] SEL_ZERO = 3'd5;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Opcodes 0xB..0xE are undefined
  function automatic logic is_illegal_op(input logic [3:0] op);
    logic res;
    case (op)
      4'hB, 4'hC, 4'hD, 4'hE: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  // Mux select for an opcode; ops that never write park the mux on zero
  function automatic logic [2:0] sel_for_op(input logic [3:0] op);
    logic [2:0] res;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: res = SEL_ALU;
      OP_LD:                         res = SEL_MEM;
      OP_LDI:                        res = SEL_IMM;
      OP_JAL:                        res = SEL_PC1;
      OP_MOV:                        res = SEL_REGB;
      default:                       res = SEL_ZERO;
    endcase
    return res;
  endfunction

  // ALU operation for an opcode; non-ALU ops leave the ALU on add
  function automatic logic [1:0] alu_for_op(input logic [3:0] op);
    logic [1:0] res;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/datapath_ctrl_fsm_mem_wait_timer.sv
// Memory wait counter: counts MEM cycles spent without mem_ready and flags
// the last allowed cycle so the sequencer can abort the access.
// CNT_W must satisfy 2**CNT_W > MEM_TIMEOUT.
module datapath_ctrl_fsm_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: clear has priority over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// Multi-cycle control sequencer feeding the 6-input writeback mux.
// Every output is a register updated on the same edge as the state, so each
// output is a clean Moore decode of the state and the held opcode. ir_load is
// therefore high during the DECODE cycle, reporting the IR load made on the
// accept edge. src_sel/alu_op only change on an accept edge, so they stay
// settled from DECODE through WB/EXEC.
module datapath_ctrl_fsm
  import datapath_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  output logic [2:0]  src_sel,
  output logic [1:0]  alu_op,
  output logic        ir_load,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        pc_en,
  output logic        busy,
  output logic        err_illegal,
  output logic        err_timeout
);

  state_t      state_r;
  logic [15:0] ir_r;
  logic [3:0]  op_s;
  logic        tmr_clr_s;
  logic        tmr_en_s;
  logic        tmr_expired_s;
  logic        unused_operand_s;

  assign op_s = ir_r[15:12];
  // Operand fields are consumed by the datapath, not by the sequencer
  assign unused_operand_s = ^ir_r[11:0];

  // Timer control: count only while waiting in MEM, clear on any MEM exit
  always_comb begin
    tmr_clr_s = 1'b1;
    tmr_en_s  = 1'b0;
    if (state_r == S_MEM) begin
      tmr_clr_s = mem_ready | tmr_expired_s;
      tmr_en_s  = ~mem_ready;
    end else begin
      tmr_clr_s = 1'b1;
      tmr_en_s  = 1'b0;
    end
  end

  datapath_ctrl_fsm_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // Sequencer: state, IR and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_FETCH;
      ir_r        <= 16'h0000;
      src_sel     <= SEL_ALU;
      alu_op      <= ALU_ADD;
      ir_load     <= 1'b0;
      reg_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      pc_en       <= 1'b0;
      busy        <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      ir_load <= 1'b0;
      reg_we  <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      pc_en   <= 1'b0;
      case (state_r)
        S_FETCH: begin
          if (instr_valid) begin
            ir_r    <= instr;
            ir_load <= 1'b1;
            src_sel <= sel_for_op(instr[15:12]);
            alu_op  <= alu_for_op(instr[15:12]);
            busy    <= 1'b1;
            state_r <= S_DECODE;
          end else begin
            busy    <= 1'b0;
            state_r <= S_FETCH;
          end
        end
        S_DECODE: begin
          if (op_s == OP_HALT) begin
            busy    <= 1'b0;
            state_r <= S_HALT;
          end else if (is_illegal_op(op_s)) begin
            // Undefined op is skipped: flag it and move the PC on
            err_illegal <= 1'b1;
            pc_en       <= 1'b1;
            busy        <= 1'b0;
            state_r     <= S_FETCH;
          end else if (op_s == OP_NOP) begin
            // NOP retires in EXEC
            pc_en   <= 1'b1;
            busy    <= 1'b1;
            state_r <= S_EXEC;
          end else begin
            busy    <= 1'b1;
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_s == OP_LD) begin
            mem_re  <= 1'b1;
            busy    <= 1'b1;
            state_r <= S_MEM;
          end else if (op_s == OP_ST) begin
            mem_we  <= 1'b1;
            busy    <= 1'b1;
            state_r <= S_MEM;
          end else if (op_s == OP_NOP) begin
            busy    <= 1'b0;
            state_r <= S_FETCH;
          end else begin
            reg_we  <= 1'b1;
            pc_en   <= 1'b1;
            busy    <= 1'b1;
            state_r <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            // Completion wins over a simultaneous timeout
            if (op_s == OP_LD) begin
              reg_we  <= 1'b1;
              pc_en   <= 1'b1;
              busy    <= 1'b1;
              state_r <= S_WB;
            end else begin
              pc_en   <= 1'b1;
              busy    <= 1'b0;
              state_r <= S_FETCH;
            end
          end else if (tmr_expired_s) begin
            // Abort: no write and no PC advance
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state_r     <= S_FETCH;
          end else begin
            mem_re  <= (op_s == OP_LD);
            mem_we  <= (op_s == OP_ST);
            busy    <= 1'b1;
            state_r <= S_MEM;
          end
        end
        S_WB: begin
          busy    <= 1'b0;
          state_r <= S_FETCH;
        end
        S_HALT: begin
          busy    <= 1'b0;
          state_r <= S_HALT;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Self-checking bench for datapath_ctrl_fsm. A behavioural model turns each
// instruction (plus the MEM cycle on which memory answers) into the expected
// per-cycle output trace after the accept edge; the DUT trace is compared.
module tb_datapath_ctrl_fsm;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  src_sel;
  logic [1:0]  alu_op;
  logic        ir_load, reg_we, mem_re, mem_we, pc_en, busy, err_illegal, err_timeout;

  int checks = 0;
  int errors = 0;

  // expected trace and the stimulus that goes with each cycle
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  bit          fch_q[$];   // DUT sits in FETCH this cycle: keep instr_valid low
  int          rdy_q[$];   // 0/1 forced mem_ready, 2 random (not sampled)
  bit          rst_q[$];

  // model state visible on the outputs
  logic [2:0] m_sel = 3'd0;
  logic [1:0] m_alu = 2'd0;
  logic       m_eill = 1'b0;
  logic       m_eto = 1'b0;

  datapath_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .src_sel(src_sel), .alu_op(alu_op),
    .ir_load(ir_load), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .pc_en(pc_en), .busy(busy), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] obs_vec();
    return {src_sel, alu_op, ir_load, reg_we, mem_re, mem_we, pc_en, busy,
            err_illegal, err_timeout};
  endfunction

  task automatic model_reset();
    m_sel = 3'd0; m_alu = 2'd0; m_eill = 1'b0; m_eto = 1'b0;
  endtask

  task automatic push(input bit il, input bit rw, input bit mr, input bit mw,
                      input bit pe, input bit bz, input bit fch, input int rdy);
    exp_q.push_back({m_sel, m_alu, il, rw, mr, mw, pe, bz, m_eill, m_eto});
    fch_q.push_back(fch);
    rdy_q.push_back(rdy);
    rst_q.push_back(1'b0);
  endtask

  // Expected trace for one instruction, cycle 1 = first cycle after accept.
  // ready_at = MEM cycle (1-based) on which mem_ready is high; 0 = never.
  task automatic model_instr(input logic [15:0] ins, input int ready_at);
    logic [3:0] op;
    op = ins[15:12];
    exp_q.delete(); fch_q.delete(); rdy_q.delete(); rst_q.delete();
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: m_sel = 3'd0;
      4'h5: m_sel = 3'd1;
      4'h7: m_sel = 3'd2;
      4'h8: m_sel = 3'd3;
      4'h9: m_sel = 3'd4;
      default: m_sel = 3'd5;
    endcase
    m_alu = (op >= 4'd1 && op <= 4'd4) ? 2'(op - 4'd1) : 2'd0;
    push(1, 0, 0, 0, 0, 1, 0, 2);                       // decode
    if (op == 4'hF) begin
      for (int k = 0; k < 6; k++) push(0, 0, 0, 0, 0, 0, 0, 2);
    end else if (op >= 4'hB) begin
      m_eill = 1'b1;
      push(0, 0, 0, 0, 1, 0, 1, 2);                     // skipped, PC moves
    end else if (op == 4'h0) begin
      push(0, 0, 0, 0, 1, 1, 0, 2);                     // retire in exec
      push(0, 0, 0, 0, 0, 0, 1, 2);
    end else if (op == 4'h5 || op == 4'h6) begin
      push(0, 0, 0, 0, 0, 1, 0, 2);                     // exec
      for (int n = 1; n <= TO; n++) begin
        push(0, 0, op == 4'h5, op == 4'h6, 0, 1, 0, (n == ready_at) ? 1 : 0);
        if (n == ready_at) begin
          if (op == 4'h5) begin
            push(0, 1, 0, 0, 1, 1, 0, 2);
            push(0, 0, 0, 0, 0, 0, 1, 2);
          end else begin
            push(0, 0, 0, 0, 1, 0, 1, 2);
          end
          break;
        end
        if (n == TO) begin
          m_eto = 1'b1;
          push(0, 0, 0, 0, 0, 0, 1, 2);
        end
      end
    end else begin
      push(0, 0, 0, 0, 0, 1, 0, 2);                     // exec
      push(0, 1, 0, 0, 1, 1, 0, 2);                     // writeback
      push(0, 0, 0, 0, 0, 0, 1, 2);
    end
  endtask

  // Present ins for one cycle (DUT in FETCH), then play the stimulus
  // columns of the model trace while recording the outputs.
  task automatic issue(input logic [15:0] ins);
    obs_q.delete();
    instr = ins; instr_valid = 1'b1; mem_ready = 1'($urandom);
    @(posedge clk); #1;
    for (int c = 0; c < exp_q.size(); c++) begin
      obs_q.push_back(obs_vec());
      instr       = 16'($urandom);
      instr_valid = fch_q[c] ? 1'b0 : 1'($urandom);
      mem_ready   = (rdy_q[c] == 2) ? 1'($urandom) : 1'(rdy_q[c]);
      rst         = rst_q[c];
      if (c < exp_q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; instr = 16'h1234; mem_ready = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== 13'h0000) begin
        errors++; $display("FAIL reset cyc%0d: got %h want %h", k, obs_vec(), 13'h0000);
      end
    end
    rst = 1'b0; instr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      instr = 16'($urandom); mem_ready = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== 13'h0000) begin
        errors++; $display("FAIL idle cyc%0d: got %h want %h", k, obs_vec(), 13'h0000);
      end
    end
  endtask

  task automatic test_alu();
    for (int t = 0; t < 6; t++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(1, 4)), 12'($urandom)};
      model_instr(ins, 0);
      issue(ins);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL alu %h cyc%0d: got %h want %h", ins, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_writes();
    logic [3:0] ops[5];
    ops = '{4'h7, 4'h8, 4'h9, 4'hA, 4'h0};
    for (int t = 0; t < 5; t++) begin
      logic [15:0] ins;
      ins = {ops[t], 12'($urandom)};
      model_instr(ins, 0);
      issue(ins);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL writes %h cyc%0d: got %h want %h", ins, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mem();
    for (int t = 0; t < 6; t++) begin
      logic [15:0] ins;
      int ra;
      if (t == 0) begin ins = 16'h5abc; ra = 2; end
      else if (t == 1) begin ins = 16'h6123; ra = 1; end
      else begin ins = {($urandom_range(0, 1) == 1) ? 4'h5 : 4'h6, 12'($urandom)}; ra = $urandom_range(1, TO); end
      model_instr(ins, ra);
      issue(ins);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL mem %h rdy%0d cyc%0d: got %h want %h", ins, ra, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] ins_l[3];
    int          ra_l[3];
    ins_l = '{16'h5001, 16'h5002, 16'h6003};
    ra_l  = '{0, TO, 0};
    for (int t = 0; t < 3; t++) begin
      model_instr(ins_l[t], ra_l[t]);
      issue(ins_l[t]);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL timeout %h rdy%0d cyc%0d: got %h want %h", ins_l[t], ra_l[t], i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    for (int t = 0; t < 3; t++) begin
      logic [15:0] ins;
      ins = (t == 0) ? 16'hC000 : {4'($urandom_range(11, 14)), 12'($urandom)};
      model_instr(ins, 0);
      issue(ins);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL illegal %h cyc%0d: got %h want %h", ins, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 14; t++) begin
      logic [15:0] ins;
      int ra;
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      ra  = $urandom_range(0, TO);
      model_instr(ins, ra);
      issue(ins);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b %h rdy%0d cyc%0d: got %h want %h", ins, ra, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // rst during the EXEC cycle of MOV: outputs and err flags clear, no write
    model_instr(16'h9555, 0);
    exp_q = exp_q[0:1]; fch_q = fch_q[0:1]; rdy_q = rdy_q[0:1]; rst_q = rst_q[0:1];
    rst_q[1] = 1'b1;
    model_reset();
    push(0, 0, 0, 0, 0, 0, 1, 2);
    push(0, 0, 0, 0, 0, 0, 1, 2);
    issue(16'h9555);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL reset_mid cyc%0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_halt();
    model_instr(16'hF000, 0);
    issue(16'hF000);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL halt cyc%0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    // only reset leaves HALT
    instr_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (obs_vec() !== 13'h0000) begin
      errors++; $display("FAIL halt_reset: got %h want %h", obs_vec(), 13'h0000);
    end
    model_instr(16'h2f0f, 0);
    issue(16'h2f0f);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL after_halt cyc%0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_writes();
    test_mem();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
